telas_transicao: RTL and testbench
==================================

Name: telas_transicao

Overview:
- Parametrised successor to the fixed 4-screen RGB selector.
- Selects one of NUM_TELAS full-screen RGB sources by `estado` and drives registered R/G/B.
- Screen changes are frame-synchronous and use a brightness fade: old screen fades to black, new screen fades in.
- Sits between the per-screen generators and the VGA output stage; also forces black outside the active area.

Parameters:
- NUM_TELAS, 4, number of screen sources.
- SEL_W, 2, width of `estado`/`tela_atual`; 2**SEL_W >= NUM_TELAS.
- COLOR_W, 8, bits per colour channel.
- FADE_STEPS, 16, brightness levels; power of 2, >= 2.
- FRAMES_PER_STEP, 2, frame ticks per brightness step; >= 1.
- H_ACTIVE, 640, visible columns.
- V_ACTIVE, 480, visible lines.
- FADE_EN, 1, 1 = fade transitions; 0 = hard switch at the next frame tick.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- h_counter  in  10  current pixel column.
- v_counter  in  10  current line.
- estado  in  SEL_W  requested screen index.
- rgb_telas  in  NUM_TELAS*3*COLOR_W  packed sources; screen i at [i*3*COLOR_W +: 3*COLOR_W], ordered {R,G,B} with R most significant.
- R  out  COLOR_W  red, registered.
- G  out  COLOR_W  green, registered.
- B  out  COLOR_W  blue, registered.
- tela_atual  out  SEL_W  screen currently displayed.
- transicao_ativa  out  1  high while in FADE_OUT or FADE_IN.

Behaviour:
- Reset (synchronous, active-high) sets:
  - R=G=B=0, tela_atual=0, alvo=0.
  - nivel=FADE_STEPS, state=ESTAVEL, transicao_ativa=0.
  - Frame-tick edge register cleared.
- frame_tick:
  - cond = (h_counter==0 && v_counter==V_ACTIVE).
  - frame_tick = cond && !cond_d, where cond_d is cond registered.
  - Exactly one clk pulse per frame, regardless of the clk-to-pixel-clock ratio.
- Step counter: counts frame_ticks 0..FRAMES_PER_STEP-1; `step` pulses on the tick that wraps it. The counter is cleared on entering FADE_OUT from ESTAVEL.
- Valid request: `estado` < NUM_TELAS. Out-of-range values never start or redirect a transition.
- State ESTAVEL:
  - Valid estado != tela_atual → alvo=estado, go to FADE_OUT; transicao_ativa=1 from the next cycle.
- State FADE_OUT:
  - On each step, nivel decrements by 1.
  - Any valid estado updates alvo every cycle; the latest request wins.
  - When nivel becomes 0: tela_atual=alvo, go to FADE_IN.
  - If alvo equals the old tela_atual at that point, the fade-in proceeds anyway.
- State FADE_IN:
  - On each step, nivel increments by 1.
  - When nivel reaches FADE_STEPS: go to ESTAVEL, transicao_ativa=0.
  - Valid estado != tela_atual → alvo=estado, go to FADE_OUT, continuing down from the current nivel (no jump).
- FADE_EN=0:
  - ESTAVEL with a pending valid request → tela_atual=estado on the next frame_tick.
  - nivel stays FADE_STEPS; transicao_ativa stays 0.
- Pixel path, 1-cycle latency from h/v/rgb inputs:
  - If h_counter>=H_ACTIVE or v_counter>=V_ACTIVE: output 0.
  - Otherwise each channel = (src * nivel) >> log2(FADE_STEPS), with src taken from screen tela_atual.
  - Product width is COLOR_W+log2(FADE_STEPS)+1; truncate after the shift.
  - nivel==FADE_STEPS gives src exactly; nivel==0 gives 0.
- Outputs update every clk, not only on counter change.
- Reset mid-transition: abort immediately to the reset values; no partial fade state survives.
- Transition duration (FADE_EN=1, uninterrupted): 2*FADE_STEPS*FRAMES_PER_STEP frame ticks, ±1 tick for step-counter phase.

Test Plan:
- Reset with estado=0, screen 0 = 0xFF8040, h=10, v=10 → after reset: R/G/B=0. One cycle after the first post-reset clock: R=0xFF, G=0x80, B=0x40; tela_atual=0; transicao_ativa=0.
- Active-area and blanking (defaults), stable screen 0 = 0xFF8040:
  - Stimulus: h=640,v=10, then h=10,v=480, then h=639,v=479.
  - Response: 0x000000, 0x000000, 0xFF8040.
- Full fade (defaults), screen 0 = 0xFF8040, screen 2 = 0x00FF00; estado 0→2, then frame_ticks:
  - After 16 ticks: nivel=8, output 0x7F4020.
  - After 32 ticks: tela_atual=2, output 0.
  - After 48 ticks: output 0x007F00.
  - After 64 ticks: output 0x00FF00, transicao_ativa=0.
- Redirect during fade-in: estado→2, then estado=3 at nivel=4 in FADE_IN → state FADE_OUT from nivel 4; tela_atual becomes 3 after 8 more ticks; no output step above the nivel-4 brightness.
- Out-of-range and hard switch, NUM_TELAS=3:
  - estado=3 → no transition; tela_atual unchanged for 100 frames.
  - FADE_EN=0 with estado 0→1 → tela_atual=1 exactly at the next frame_tick; full-brightness output; transicao_ativa never 1.
- Tick edge and reset abort:
  - clk = 2× pixel rate, so (0,480) is held 2 cycles → exactly one frame_tick.
  - reset asserted mid-FADE_OUT → next cycle R/G/B=0, tela_atual=0, transicao_ativa=0.

Source files
------------

// File: rtl/telas_transicao.sv
// Screen selector with frame-synchronous fade transitions.
// Picks one of NUM_TELAS RGB sources, scales it by a brightness level and blanks outside the active area.
module telas_transicao #(
  parameter int NUM_TELAS       = 4,
  parameter int SEL_W           = 2,
  parameter int COLOR_W         = 8,
  parameter int FADE_STEPS      = 16,
  parameter int FRAMES_PER_STEP = 2,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int FADE_EN         = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [9:0]                       h_counter,
  input  logic [9:0]                       v_counter,
  input  logic [SEL_W-1:0]                 estado,
  input  logic [NUM_TELAS*3*COLOR_W-1:0]   rgb_telas,
  output logic [COLOR_W-1:0]               R,
  output logic [COLOR_W-1:0]               G,
  output logic [COLOR_W-1:0]               B,
  output logic [SEL_W-1:0]                 tela_atual,
  output logic                             transicao_ativa
);

  localparam int LVL_SH = $clog2(FADE_STEPS);
  localparam int LVL_W  = LVL_SH + 1;
  localparam int PROD_W = COLOR_W + LVL_SH + 1;
  localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [LVL_W-1:0] NIVEL_MAX = LVL_W'(FADE_STEPS);
  localparam logic [LVL_W-1:0] NIVEL_UM  = LVL_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] CNT_UM    = CNT_W'(1);
  localparam logic [9:0]       H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]       V_LIM     = 10'(V_ACTIVE);
  localparam logic [SEL_W:0]   NUM_LIM   = (SEL_W+1)'(NUM_TELAS);

  typedef enum logic [1:0] {
    ESTAVEL  = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fase_t;

  fase_t              fase, fase_nxt;
  logic [LVL_W-1:0]   nivel, nivel_nxt;
  logic [SEL_W-1:0]   alvo, alvo_nxt, tela_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               cond, cond_d, frame_tick, step;
  logic               req_valida, req_nova;
  logic [3*COLOR_W-1:0] src;

  // The tick position may be held for several clk cycles; only its first cycle counts.
  assign cond       = (h_counter == 10'd0) && (v_counter == V_LIM);
  assign frame_tick = cond && !cond_d;
  assign step       = frame_tick && (cnt == CNT_LAST);

  assign req_valida = ({1'b0, estado} < NUM_LIM);
  assign req_nova   = req_valida && (estado != tela_atual);

  assign transicao_ativa = (fase != ESTAVEL);

  always_comb begin
    fase_nxt  = fase;
    nivel_nxt = nivel;
    alvo_nxt  = alvo;
    tela_nxt  = tela_atual;
    cnt_nxt   = cnt;
    if (frame_tick) cnt_nxt = step ? '0 : cnt + CNT_UM;
    case (fase)
      ESTAVEL: begin
        if (FADE_EN == 0) begin
          if (frame_tick && req_nova) tela_nxt = estado;
        end else if (req_nova) begin
          alvo_nxt = estado;
          fase_nxt = FADE_OUT;
          cnt_nxt  = '0;
        end
      end
      FADE_OUT: begin
        if (req_valida) alvo_nxt = estado;
        if (step) begin
          // A redirect taken right at black re-enters here at 0; clamp rather than wrap.
          if (nivel <= NIVEL_UM) begin
            nivel_nxt = '0;
            tela_nxt  = alvo_nxt;
            fase_nxt  = FADE_IN;
          end else begin
            nivel_nxt = nivel - NIVEL_UM;
          end
        end
      end
      FADE_IN: begin
        if (req_nova) begin
          alvo_nxt = estado;
          fase_nxt = FADE_OUT;
        end else if (step) begin
          nivel_nxt = nivel + NIVEL_UM;
          if (nivel_nxt == NIVEL_MAX) fase_nxt = ESTAVEL;
        end
      end
      default: fase_nxt = ESTAVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fase       <= ESTAVEL;
      nivel      <= NIVEL_MAX;
      alvo       <= '0;
      tela_atual <= '0;
      cnt        <= '0;
      cond_d     <= 1'b0;
    end else begin
      fase       <= fase_nxt;
      nivel      <= nivel_nxt;
      alvo       <= alvo_nxt;
      tela_atual <= tela_nxt;
      cnt        <= cnt_nxt;
      cond_d     <= cond;
    end
  end

  always_comb begin
    src = '0;
    for (int i = 0; i < NUM_TELAS; i++) begin
      if (tela_atual == SEL_W'(i)) src = rgb_telas[i*3*COLOR_W +: 3*COLOR_W];
    end
  end

  function automatic logic [COLOR_W-1:0] escala(input logic [COLOR_W-1:0] c,
                                                input logic [LVL_W-1:0] n);
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(n);
    return COLOR_W'(p >> LVL_SH);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || h_counter >= H_LIM || v_counter >= V_LIM) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= escala(src[3*COLOR_W-1 -: COLOR_W], nivel);
      G <= escala(src[2*COLOR_W-1 -: COLOR_W], nivel);
      B <= escala(src[COLOR_W-1:0], nivel);
    end
  end

endmodule

// File: tb/tb_telas_transicao.sv
// Bench for telas_transicao: three parameter variants driven by shared pixel counters.
// Directed sequences check fixed values; a frame-level reference model checks every cycle.
module tb_telas_transicao;

  logic        clk;
  logic        reset;
  logic [9:0]  h, v;
  logic [95:0] rgb;
  logic [1:0]  est_v [3];
  logic [7:0]  r_o [3];
  logic [7:0]  g_o [3];
  logic [7:0]  b_o [3];
  logic [1:0]  tela_o [3];
  logic        act_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Per-instance parameters as seen by the model.
  int p_num [3] = '{4, 3, 3};
  int p_fs  [3] = '{16, 4, 16};
  int p_fps [3] = '{2, 1, 2};
  int p_fe  [3] = '{1, 1, 0};

  telas_transicao u_dut0 (
    .clk(clk), .reset(reset), .h_counter(h), .v_counter(v), .estado(est_v[0]),
    .rgb_telas(rgb), .R(r_o[0]), .G(g_o[0]), .B(b_o[0]),
    .tela_atual(tela_o[0]), .transicao_ativa(act_o[0])
  );

  telas_transicao #(.NUM_TELAS(3), .FADE_STEPS(4), .FRAMES_PER_STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .h_counter(h), .v_counter(v), .estado(est_v[1]),
    .rgb_telas(rgb[71:0]), .R(r_o[1]), .G(g_o[1]), .B(b_o[1]),
    .tela_atual(tela_o[1]), .transicao_ativa(act_o[1])
  );

  telas_transicao #(.NUM_TELAS(3), .FADE_EN(0)) u_dut2 (
    .clk(clk), .reset(reset), .h_counter(h), .v_counter(v), .estado(est_v[2]),
    .rgb_telas(rgb[71:0]), .R(r_o[2]), .G(g_o[2]), .B(b_o[2]),
    .tela_atual(tela_o[2]), .transicao_ativa(act_o[2])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: brightness level, direction of fade (-1 out, +1 in, 0 none)
  int         m_tela [3];
  int         m_alvo [3];
  int         m_lvl  [3];
  int         m_dir  [3];
  int         m_cnt  [3];
  bit         m_cond_d;
  logic [23:0] exp_rgb [3];
  int         exp_tela [3];
  bit         exp_act [3];

  task automatic model_cycle();
    bit cond, tick, stepped, valid;
    int est, fs;
    int chan [3];
    logic [95:0] sh;
    cond = (int'(h) == 0) && (int'(v) == 480);
    tick = cond && !m_cond_d;
    for (int k = 0; k < 3; k++) begin
      fs    = p_fs[k];
      est   = int'(est_v[k]);
      valid = est < p_num[k];
      for (int c = 0; c < 3; c++) begin
        sh = rgb >> (m_tela[k] * 24 + (2 - c) * 8);
        chan[c] = (int'(sh[7:0]) * m_lvl[k]) / fs;
      end
      if (int'(h) >= 640 || int'(v) >= 480) exp_rgb[k] = 24'h0;
      else exp_rgb[k] = {8'(chan[0]), 8'(chan[1]), 8'(chan[2])};
      stepped = 1'b0;
      if (reset) begin
        m_tela[k] = 0; m_alvo[k] = 0; m_lvl[k] = fs; m_dir[k] = 0; m_cnt[k] = 0;
        exp_rgb[k] = 24'h0;
      end else begin
        if (tick) begin
          m_cnt[k]++;
          if (m_cnt[k] == p_fps[k]) begin m_cnt[k] = 0; stepped = 1'b1; end
        end
        if (p_fe[k] == 0) begin
          if (tick && valid && est != m_tela[k]) m_tela[k] = est;
        end else if (m_dir[k] == 0) begin
          if (valid && est != m_tela[k]) begin
            m_alvo[k] = est; m_dir[k] = -1; m_cnt[k] = 0;
          end
        end else if (m_dir[k] > 0 && valid && est != m_tela[k]) begin
          m_alvo[k] = est; m_dir[k] = -1;
        end else begin
          if (m_dir[k] < 0 && valid) m_alvo[k] = est;
          if (stepped) begin
            m_lvl[k] = m_lvl[k] + m_dir[k];
            if (m_lvl[k] < 0) m_lvl[k] = 0;
            if (m_dir[k] < 0 && m_lvl[k] == 0) begin
              m_tela[k] = m_alvo[k]; m_dir[k] = 1;
            end else if (m_dir[k] > 0 && m_lvl[k] == fs) begin
              m_dir[k] = 0;
            end
          end
        end
      end
      exp_tela[k] = m_tela[k];
      exp_act[k]  = (m_dir[k] != 0);
    end
    m_cond_d = reset ? 1'b0 : cond;
  endtask

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [23:0] rgb_of(input int k);
    return {r_o[k], g_o[k], b_o[k]};
  endfunction

  // driver tasks
  task automatic cycle();
    model_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_rgb[%0d]", k), 32'(rgb_of(k)), 32'(exp_rgb[k]));
      chk($sformatf("model_tela[%0d]", k), 32'(tela_o[k]), 32'(exp_tela[k]));
      chk($sformatf("model_ativa[%0d]", k), 32'(act_o[k]), 32'(exp_act[k]));
    end
  endtask

  // clk runs at twice the pixel rate, so the tick position is held for two cycles
  task automatic tick();
    h = 10'd0; v = 10'd480;
    cycle();
    cycle();
    h = 10'd10; v = 10'd10;
    cycle();
  endtask

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [23:0] rgb;
  } vec_t;

  vec_t tab [5];
  int   r;

  initial begin
    tab[0] = '{10'd640, 10'd10,  24'h000000};
    tab[1] = '{10'd10,  10'd480, 24'h000000};
    tab[2] = '{10'd639, 10'd479, 24'hFF8040};
    tab[3] = '{10'd0,   10'd0,   24'hFF8040};
    tab[4] = '{10'd700, 10'd500, 24'h000000};

    rgb = {24'h123456, 24'h00FF00, 24'h204080, 24'hFF8040};
    for (int k = 0; k < 3; k++) est_v[k] = 2'd0;
    h = 10'd10; v = 10'd10;
    reset = 1'b1;
    m_cond_d = 1'b0;

    cycle();
    cycle();
    chk("reset_rgb", 32'(rgb_of(0)), 32'h0);
    chk("reset_tela", 32'(tela_o[0]), 32'h0);
    reset = 1'b0;
    cycle();
    chk("first_pixel", 32'(rgb_of(0)), 32'hFF8040);
    chk("first_ativa", 32'(act_o[0]), 32'h0);

    for (int i = 0; i < 5; i++) begin
      h = tab[i].h; v = tab[i].v;
      cycle();
      chk($sformatf("blank_tab[%0d]", i), 32'(rgb_of(0)), 32'(tab[i].rgb));
    end
    h = 10'd10; v = 10'd10;

    // one held tick position must give exactly one step (FADE_STEPS=4, one frame per step)
    est_v[1] = 2'd1;
    cycle();
    tick();
    chk("tick_edge", 32'(rgb_of(1)), 32'hBF6030);

    // hard switch waits for the frame tick
    est_v[2] = 2'd1;
    cycle();
    cycle();
    chk("hard_before", 32'(tela_o[2]), 32'h0);
    h = 10'd0; v = 10'd480;
    cycle();
    chk("hard_at_tick", 32'(tela_o[2]), 32'h1);
    cycle();
    h = 10'd10; v = 10'd10;
    cycle();
    chk("hard_rgb", 32'(rgb_of(2)), 32'h204080);
    chk("hard_ativa", 32'(act_o[2]), 32'h0);

    // full fade 0 -> 2; out-of-range request held on the 3-screen fader
    est_v[0] = 2'd2;
    est_v[1] = 2'd3;
    cycle();
    chk("fade_start_ativa", 32'(act_o[0]), 32'h1);
    for (int t = 1; t <= 64; t++) begin
      tick();
      if (t == 16) chk("fade_16", 32'(rgb_of(0)), 32'h7F4020);
      if (t == 32) begin
        chk("fade_32_tela", 32'(tela_o[0]), 32'h2);
        chk("fade_32_rgb", 32'(rgb_of(0)), 32'h0);
      end
      if (t == 48) chk("fade_48", 32'(rgb_of(0)), 32'h007F00);
      if (t == 64) begin
        chk("fade_64_rgb", 32'(rgb_of(0)), 32'h00FF00);
        chk("fade_64_ativa", 32'(act_o[0]), 32'h0);
      end
    end
    for (int t = 0; t < 100; t++) tick();
    chk("oor_tela", 32'(tela_o[1]), 32'h1);
    chk("oor_ativa", 32'(act_o[1]), 32'h0);

    // reset in the middle of a fade-out
    est_v[0] = 2'd0;
    cycle();
    for (int t = 0; t < 5; t++) tick();
    chk("abort_pre_ativa", 32'(act_o[0]), 32'h1);
    reset = 1'b1;
    cycle();
    chk("abort_rgb", 32'(rgb_of(0)), 32'h0);
    chk("abort_tela", 32'(tela_o[0]), 32'h0);
    chk("abort_ativa", 32'(act_o[0]), 32'h0);
    reset = 1'b0;

    // redirect to screen 3 while fading in at level 4
    est_v[0] = 2'd2;
    cycle();
    for (int t = 0; t < 40; t++) tick();
    chk("redir_tela", 32'(tela_o[0]), 32'h2);
    chk("redir_rgb", 32'(rgb_of(0)), 32'h003F00);
    est_v[0] = 2'd3;
    cycle();
    chk("redir_ativa", 32'(act_o[0]), 32'h1);
    for (int t = 0; t < 8; t++) begin
      tick();
      n_tests++;
      if (rgb_of(0) > 24'h003F00) begin
        n_fail++;
        $display("FAIL redir_bound: got %06h, must not exceed 003f00", rgb_of(0));
      end
    end
    chk("redir_tela3", 32'(tela_o[0]), 32'h3);
    chk("redir_black", 32'(rgb_of(0)), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 99) < 8) est_v[k] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) rgb = {$urandom(), $urandom(), $urandom()};
      reset = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 99);
      if (r < 30) begin
        h = 10'd0; v = 10'd480;
        repeat ($urandom_range(1, 3)) cycle();
      end else begin
        h = 10'($urandom_range(0, 700));
        v = 10'($urandom_range(0, 520));
        cycle();
      end
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
